ucaspian_host_rx: RTL and testbench

//   Host-side decoder for the uCaspian TX byte stream (write_data/write_vld/write_rdy).

---
 rtl/ucaspian_host_rx.sv | 207 ++++++++++++++++++++
 tb/tb_ucaspian_host_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucaspian_host_rx.sv
// Host-side decoder for the uCaspian TX byte stream: turns ACK/TIME/METRIC/FIRE
// response packets into one handshaked event each, with protocol-error detection.
module ucaspian_host_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_vld,
  output logic             rx_rdy,
  output logic [2:0]       ev_type,
  output logic [7:0]       ev_addr,
  output logic [7:0]       ev_value,
  output logic [31:0]      ev_time,
  output logic             ev_vld,
  input  logic             ev_rdy,
  output logic             proto_err,
  output logic [CNT_W-1:0] fire_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_EMIT} state_t;
  typedef enum logic [2:0] {EV_ACK = 3'd0, EV_TIME = 3'd1, EV_METRIC = 3'd2, EV_FIRE = 3'd3} ev_t;

  state_t           state_q, state_d;
  ev_t              hdr_q, hdr_d;
  ev_t              ev_type_q, ev_type_d;
  logic [2:0]       rem_q, rem_d;
  logic [31:0]      sh_q, sh_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rdy_q, rdy_d;
  logic [7:0]       ev_addr_q, ev_addr_d;
  logic [7:0]       ev_value_q, ev_value_d;
  logic [31:0]      ev_time_q, ev_time_d;
  logic             ev_vld_q, ev_vld_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] fire_q, fire_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic [31:0]      time_q, time_d;

  logic             xfer;
  logic [31:0]      sh_nxt;

  assign xfer   = rx_vld & rdy_q;
  assign sh_nxt = {sh_q[23:0], rx_data};

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    ev_type_d  = ev_type_q;
    rem_d      = rem_q;
    sh_d       = sh_q;
    tmo_d      = tmo_q;
    rdy_d      = rdy_q;
    ev_addr_d  = ev_addr_q;
    ev_value_d = ev_value_q;
    ev_time_d  = ev_time_q;
    ev_vld_d   = ev_vld_q;
    err_d      = 1'b0;
    fire_d     = fire_q;
    time_d     = time_q;

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        tmo_d = '0;
        if (xfer) begin
          sh_d = '0;
          case (rx_data)
            8'h01: begin
              state_d    = S_EMIT;
              rdy_d      = 1'b0;
              ev_vld_d   = 1'b1;
              ev_type_d  = EV_ACK;
              ev_addr_d  = '0;
              ev_value_d = '0;
              ev_time_d  = '0;
            end
            8'h02: begin
              state_d = S_PAYLOAD;
              hdr_d   = EV_TIME;
              rem_d   = 3'd4;
            end
            8'h03: begin
              state_d = S_PAYLOAD;
              hdr_d   = EV_METRIC;
              rem_d   = 3'd2;
            end
            8'h04: begin
              state_d = S_PAYLOAD;
              hdr_d   = EV_FIRE;
              rem_d   = 3'd1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_PAYLOAD: begin
        if (xfer) begin
          sh_d  = sh_nxt;
          tmo_d = '0;
          rem_d = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            // Fields are built from sh_nxt so the event is ready the cycle after the last byte.
            state_d    = S_EMIT;
            rdy_d      = 1'b0;
            ev_vld_d   = 1'b1;
            ev_type_d  = hdr_q;
            ev_addr_d  = '0;
            ev_value_d = '0;
            ev_time_d  = '0;
            case (hdr_q)
              EV_TIME: begin
                ev_time_d = sh_nxt;
                time_d    = sh_nxt;
              end
              EV_METRIC: begin
                ev_addr_d  = sh_nxt[15:8];
                ev_value_d = sh_nxt[7:0];
              end
              EV_FIRE: begin
                ev_addr_d = sh_nxt[7:0];
                ev_time_d = time_q;
              end
              default: ;
            endcase
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_EMIT: begin
        if (ev_rdy) begin
          state_d    = S_IDLE;
          rdy_d      = 1'b1;
          ev_vld_d   = 1'b0;
          ev_type_d  = EV_ACK;
          ev_addr_d  = '0;
          ev_value_d = '0;
          ev_time_d  = '0;
          if (ev_type_q == EV_FIRE && fire_q != '1) fire_d = fire_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    errc_d = errc_q;
    if (err_d && errc_q != '1) errc_d = errc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      hdr_q      <= EV_ACK;
      ev_type_q  <= EV_ACK;
      rem_q      <= '0;
      sh_q       <= '0;
      tmo_q      <= '0;
      rdy_q      <= 1'b0;
      ev_addr_q  <= '0;
      ev_value_q <= '0;
      ev_time_q  <= '0;
      ev_vld_q   <= 1'b0;
      err_q      <= 1'b0;
      fire_q     <= '0;
      errc_q     <= '0;
      time_q     <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      ev_type_q  <= ev_type_d;
      rem_q      <= rem_d;
      sh_q       <= sh_d;
      tmo_q      <= tmo_d;
      rdy_q      <= rdy_d;
      ev_addr_q  <= ev_addr_d;
      ev_value_q <= ev_value_d;
      ev_time_q  <= ev_time_d;
      ev_vld_q   <= ev_vld_d;
      err_q      <= err_d;
      fire_q     <= fire_d;
      errc_q     <= errc_d;
      time_q     <= time_d;
    end
  end

  assign rx_rdy     = rdy_q;
  assign ev_type    = ev_type_q;
  assign ev_addr    = ev_addr_q;
  assign ev_value   = ev_value_q;
  assign ev_time    = ev_time_q;
  assign ev_vld     = ev_vld_q;
  assign proto_err  = err_q;
  assign fire_count = fire_q;
  assign err_count  = errc_q;

endmodule

// File: tb/tb_ucaspian_host_rx.sv
// Scoreboard bench for ucaspian_host_rx: packet-level model pushes expected events,
// a negedge monitor pops and compares on every event handshake.
module tb_ucaspian_host_rx;

  localparam int unsigned TMO   = 16;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_vld = 1'b0;
  logic             rx_rdy;
  logic [2:0]       ev_type;
  logic [7:0]       ev_addr;
  logic [7:0]       ev_value;
  logic [31:0]      ev_time;
  logic             ev_vld;
  logic             ev_rdy = 1'b0;
  logic             proto_err;
  logic [CNT_W-1:0] fire_count;
  logic [CNT_W-1:0] err_count;

  ucaspian_host_rx #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .ev_type(ev_type), .ev_addr(ev_addr), .ev_value(ev_value), .ev_time(ev_time),
    .ev_vld(ev_vld), .ev_rdy(ev_rdy), .proto_err(proto_err),
    .fire_count(fire_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [7:0]  a;
    logic [7:0]  v;
    logic [31:0] tm;
  } ev_s;

  ev_s         expq[$];
  ev_s         mon_e;
  int          checks = 0;
  int          failures = 0;
  int          err_seen = 0;
  int          rdy_mode = 2;
  logic [31:0] m_time = '0;
  int          exp_fire = 0;
  int          exp_err = 0;
  int          err_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [2:0] t, input logic [7:0] a, input logic [7:0] v,
                         input logic [31:0] tm);
    ev_s e;
    e.t = t; e.a = a; e.v = v; e.tm = tm;
    expq.push_back(e);
  endtask

  // Consumer readiness changes only at posedge+1.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       ev_rdy = 1'b1;
      1:       ev_rdy = 1'($urandom_range(0, 1));
      default: ev_rdy = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset_n && proto_err) err_seen++;
    if (reset_n && ev_vld && ev_rdy) begin
      if (expq.size() == 0) chk("unexpected_event", 32'd1, 32'd0);
      else begin
        mon_e = expq.pop_front();
        chk("ev_type", 32'(ev_type), 32'(mon_e.t));
        chk("ev_addr", 32'(ev_addr), 32'(mon_e.a));
        chk("ev_value", 32'(ev_value), 32'(mon_e.v));
        chk("ev_time", ev_time, mon_e.tm);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = b;
    rx_vld  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_rdy && n < 300) begin @(negedge clk); n++; end
    if (!rx_rdy) chk("rx_rdy_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("drain", 32'(expq.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int          n;
    int          r;
    int          gap;
    logic [7:0]  hdr;
    logic [7:0]  a;
    logic [7:0]  v;
    logic [31:0] t;

    // Reset state
    #12;
    chk("rst_rx_rdy", 32'(rx_rdy), 32'd0);
    chk("rst_ev_vld", 32'(ev_vld), 32'd0);
    chk("rst_fields", {ev_time[31:8], ev_time[7:0] | ev_addr | ev_value}, 32'd0);
    chk("rst_err", 32'({proto_err, fire_count, err_count}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_release", 32'(rx_rdy), 32'd1);

    // ACK with consumer stalled
    push_ev(3'd0, 8'h00, 8'h00, 32'h0);
    send_byte(8'h01, 0);
    chk("ack_latency_vld", 32'(ev_vld), 32'd1);
    chk("ack_type", 32'(ev_type), 32'd0);
    chk("ack_fields", ev_time | 32'(ev_addr) | 32'(ev_value), 32'd0);
    chk("ack_rx_rdy_low", 32'(rx_rdy), 32'd0);
    idle(3);
    chk("ack_rx_rdy_held", 32'(rx_rdy), 32'd0);
    rdy_mode = 0;
    drain();

    // TIME then FIRE carrying that time
    push_ev(3'd1, 8'h00, 8'h00, 32'h0000012C);
    m_time = 32'h0000012C;
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h2C, 0);
    push_ev(3'd3, 8'h7F, 8'h00, m_time);
    exp_fire++;
    send_byte(8'h04, 0); send_byte(8'h7F, 0);
    drain();
    chk("fire_count_1", 32'(fire_count), 32'(exp_fire));

    // METRIC under long backpressure
    rdy_mode = 2;
    idle(2);
    push_ev(3'd2, 8'h05, 8'hA5, 32'h0);
    send_byte(8'h03, 0); send_byte(8'h05, 0); send_byte(8'hA5, 0);
    chk("metric_vld", 32'(ev_vld), 32'd1);
    idle(20);
    chk("metric_held_vld", 32'(ev_vld), 32'd1);
    chk("metric_held_type", 32'(ev_type), 32'd2);
    chk("metric_held_addr", 32'(ev_addr), 32'h05);
    chk("metric_held_value", 32'(ev_value), 32'hA5);
    chk("metric_held_time", ev_time, 32'h0);
    chk("metric_rx_rdy_low", 32'(rx_rdy), 32'd0);
    chk("stall_no_err", 32'(err_count), 32'd0);
    rdy_mode = 0;
    drain();

    // Unknown header then ACK
    exp_err++;
    send_byte(8'h9E, 0);
    push_ev(3'd0, 8'h00, 8'h00, 32'h0);
    send_byte(8'h01, 0);
    drain();
    idle(2);
    chk("bad_hdr_err_count", 32'(err_count), 32'(exp_err));
    chk("bad_hdr_one_pulse", 32'(err_seen), 32'(exp_err));

    // Payload timeout
    send_byte(8'h03, 0); send_byte(8'h05, 0);
    n = 0;
    while (n < int'(TMO) + 5) begin
      @(posedge clk); #1; n++;
      if (proto_err) break;
    end
    chk("timeout_cycles", 32'(n), 32'(TMO));
    exp_err++;
    push_ev(3'd3, 8'h10, 8'h00, m_time);
    exp_fire++;
    send_byte(8'h04, 0); send_byte(8'h10, 0);
    drain();
    chk("timeout_err_count", 32'(err_count), 32'(exp_err));

    // Randomized packet stream with random consumer readiness
    rdy_mode = 1;
    for (int p = 0; p < 150; p++) begin
      r   = int'($urandom_range(0, 9));
      gap = int'($urandom_range(0, 3));
      if (r < 2) hdr = 8'h01;
      else if (r < 4) hdr = 8'h02;
      else if (r < 6) hdr = 8'h03;
      else if (r < 9) hdr = 8'h04;
      else begin
        hdr = 8'($urandom_range(0, 255));
        while (hdr >= 8'h01 && hdr <= 8'h04) hdr = 8'($urandom_range(0, 255));
      end
      case (hdr)
        8'h01: begin
          push_ev(3'd0, 8'h00, 8'h00, 32'h0);
          send_byte(hdr, gap);
        end
        8'h02: begin
          t = $urandom;
          push_ev(3'd1, 8'h00, 8'h00, t);
          m_time = t;
          send_byte(hdr, gap);
          send_byte(t[31:24], int'($urandom_range(0, 3)));
          send_byte(t[23:16], int'($urandom_range(0, 3)));
          send_byte(t[15:8], int'($urandom_range(0, 3)));
          send_byte(t[7:0], int'($urandom_range(0, 3)));
        end
        8'h03: begin
          a = 8'($urandom); v = 8'($urandom);
          push_ev(3'd2, a, v, 32'h0);
          send_byte(hdr, gap);
          send_byte(a, int'($urandom_range(0, 3)));
          send_byte(v, int'($urandom_range(0, 3)));
        end
        8'h04: begin
          a = 8'($urandom);
          push_ev(3'd3, a, 8'h00, m_time);
          exp_fire++;
          send_byte(hdr, gap);
          send_byte(a, int'($urandom_range(0, 3)));
        end
        default: begin
          exp_err++;
          send_byte(hdr, gap);
        end
      endcase
    end
    rdy_mode = 0;
    drain();
    idle(2);
    chk("rand_fire_count", 32'(fire_count), 32'(exp_fire));
    chk("rand_err_count", 32'(err_count), 32'(exp_err));
    chk("rand_err_pulses", 32'(err_seen), 32'(exp_err));

    // Reset in the middle of a TIME packet
    send_byte(8'h02, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_rx_rdy", 32'(rx_rdy), 32'd0);
    chk("midrst_vld_err", 32'({ev_vld, proto_err}), 32'd0);
    chk("midrst_counters", 32'({fire_count, err_count}), 32'd0);
    chk("midrst_fields", ev_time | 32'(ev_addr) | 32'(ev_value) | 32'(ev_type), 32'd0);
    m_time   = '0;
    exp_fire = 0;
    exp_err  = 0;
    err_base = err_seen;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rdy_after", 32'(rx_rdy), 32'd1);
    push_ev(3'd3, 8'h01, 8'h00, m_time);
    exp_fire++;
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    drain();
    idle(2);
    chk("midrst_fire_count", 32'(fire_count), 32'(exp_fire));
    chk("midrst_err_count", 32'(err_count), 32'(exp_err));
    chk("midrst_no_pulse", 32'(err_seen - err_base), 32'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
